core_ifetch_queue: RTL and testbench
====================================

# core_ifetch_queue

Parametrised successor to the fixed PC-register/fetch/IF-ID chain of the xrv32i core. It owns the fetch PC and issues instruction-ROM requests under a backpressure handshake. It buffers returned instructions in a DEPTH-entry prefetch queue and hands them to decode over a valid/ready interface. Jumps from execute flush the queue and squash the in-flight response; hold stalls fetch without blocking drain.

## Interface
- ADDR_W, 32, fetch address width.
- INST_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries; legal range 2..16, need not be a power of two.
- RST_ADDR, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0.
- INST_NOP, 32'h0000_0013, value driven on inst_out when the queue is empty.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- jump_flag_in  in  1  redirect fetch this cycle.
- jump_addr_in  in  ADDR_W  redirect target; bits [1:0] ignored and treated as 0.
- hold_flag_in  in  1  suppress new ROM requests.
- rom_req_out  out  1  ROM request valid.
- rom_addr_out  out  ADDR_W  ROM request address.
- rom_ready_in  in  1  ROM accepts the request this cycle.
- rom_data_in  in  INST_W  ROM read data, valid exactly 1 cycle after acceptance.
- inst_valid_out  out  1  queue head valid.
- inst_out  out  INST_W  head instruction; INST_NOP when not valid.
- inst_addr_out  out  ADDR_W  head instruction address; 0 when not valid.
- inst_ready_in  in  1  decode consumes head when valid and ready.
- count_out  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- **State.**
  - fetch_pc (ADDR_W).
  - inflight: 1 bit, response due next cycle.
  - inflight_addr.
  - drop: 1 bit, discard next response.
  - Circular queue of {addr, inst} with rd_ptr, wr_ptr and count. Pointers wrap modulo DEPTH.
- **Issue.** rom_req_out = !rst & !jump_flag_in & !hold_flag_in & (count + inflight < DEPTH).
  - rom_addr_out = fetch_pc at all times.
  - Acceptance (rom_req_out & rom_ready_in):
    - inflight <= 1;
    - inflight_addr <= fetch_pc;
    - fetch_pc <= fetch_pc + 4, modulo 2^ADDR_W.
  - No acceptance: inflight <= 0.
- **Credit rule.** The credit check ignores a same-cycle pop. This is deliberate and conservative; the queue can never overflow.
- **Response.** When inflight=1 and drop=0, {inflight_addr, rom_data_in} is written at wr_ptr and count increments. When drop=1 the response is discarded and drop clears.
- **Pop.** A pop occurs when inst_valid_out & inst_ready_in. rd_ptr advances and count decrements. A same-cycle push and pop leaves count unchanged.
- **Outputs.** inst_valid_out = (count != 0) & !jump_flag_in. Head fields come from rd_ptr; inst_out and inst_addr_out are forced to INST_NOP and 0 when not valid.
- **Jump** (priority over hold, push, pop and issue):
  - fetch_pc <= {jump_addr_in[ADDR_W-1:2], 2'b00};
  - count, rd_ptr and wr_ptr <= 0;
  - drop <= inflight_next, i.e. 1 if a request was accepted this cycle (it cannot be, because issue is gated) or a response is pending. In effect drop <= 0, and the response arriving in the jump cycle itself is discarded.
  - No pop is taken in the jump cycle.
- **Hold.** Hold only gates issue. Pending responses still land, and decode still drains the queue.
- **Stable request.** While rom_req_out=1 and rom_ready_in=0, rom_addr_out stays stable.

## Timing
- **Reset** (rst=1 at an edge):
  - fetch_pc = RST_ADDR;
  - inflight, drop, count and pointers = 0;
  - rom_req_out = 0 while rst is high;
  - inst_valid_out = 0, inst_out = INST_NOP, inst_addr_out = 0, count_out = 0.
- **Reset mid-operation.** The in-flight response is lost and nothing is written.
- **First request.** Issued in the first cycle with rst=0.
- **Latency.** Request accepted at cycle t, data at t+1, inst_valid_out at t+2 (no bypass).
- **Throughput.** With rom_ready_in=1, inst_ready_in=1 and DEPTH>=2, one instruction per cycle is sustained after the initial 2-cycle latency.
- **Jump at cycle t.**
  - No request and no valid output at t.
  - Request to the target issues at t+1.
  - Target instruction is valid at t+3.
- **Full queue** (count=DEPTH): rom_req_out=0 until a pop frees a credit. Issue resumes the cycle after the pop.
- **Empty queue with inst_ready_in=1:** no effect.

## Test plan
- **Reset and stream.** Release rst; ROM returns addr>>2 as data, ready=1, decode ready=1. Require:
  - addresses 0,4,8,... on rom_addr_out from cycle 0;
  - inst_valid_out first at cycle 2 with inst_addr_out=0;
  - one instruction per cycle thereafter.
- **Backpressure full.** Hold inst_ready_in=0 with DEPTH=4. Require:
  - count_out reaches 4;
  - rom_req_out=0;
  - exactly 4 accepted requests (addresses 0..12);
  - on ready=1, pops in order 0,4,8,12, then fetch resumes at 16.
- **Jump with in-flight response.** Assert jump_flag_in with jump_addr_in=0x103 while a response is pending. Require:
  - the pending response is discarded;
  - count_out=0 the next cycle;
  - next rom_addr_out=0x100;
  - first valid head addr=0x100 three cycles after the jump.
- **ROM stall.** Hold rom_ready_in=0 for 5 cycles. Require:
  - rom_addr_out stable and rom_req_out=1 throughout;
  - no spurious queue writes;
  - order preserved after release.
- **Hold.** Assert hold_flag_in with 2 entries queued and 1 in flight. Require:
  - rom_req_out=0;
  - the in-flight entry still lands (count 3);
  - decode drains all 3;
  - inst_out=0x00000013 when empty.
- **Wrap.** Set RST_ADDR=0xFFFFFFF8 with DEPTH=3. Require:
  - addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0;
  - queue pointer wrap-around preserves order over 10+ instructions.

Source files
------------

// File: rtl/core_ifetch_queue.sv
// core_ifetch_queue: owns the fetch PC, issues instruction-ROM requests with a
// credit check, buffers returned instructions in a DEPTH-entry circular queue
// and presents them to decode over a valid/ready handshake. A jump flushes the
// queue and discards any response that arrives while it is asserted.
module core_ifetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0,
    parameter logic [INST_W-1:0] INST_NOP = INST_W'(32'h0000_0013)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         jump_flag_in,
    input  logic [ADDR_W-1:0]            jump_addr_in,
    input  logic                         hold_flag_in,
    output logic                         rom_req_out,
    output logic [ADDR_W-1:0]            rom_addr_out,
    input  logic                         rom_ready_in,
    input  logic [INST_W-1:0]            rom_data_in,
    output logic                         inst_valid_out,
    output logic [INST_W-1:0]            inst_out,
    output logic [ADDR_W-1:0]            inst_addr_out,
    input  logic                         inst_ready_in,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);

    localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_addr;
    logic [ADDR_W-1:0] jump_target;
    logic              inflight;
    logic              drop;
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       credit_used;
    logic              accept;
    logic              push;
    logic              pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Masking the low bits keeps jump targets word aligned.
    assign jump_target = jump_addr_in & ~ADDR_W'(3);

    // Queue slots already spoken for: stored entries plus the pending response.
    // A same-cycle pop is deliberately not credited, so overflow is impossible.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};

    assign rom_req_out  = !rst && !jump_flag_in && !hold_flag_in &&
                          (credit_used < (CW+1)'(DEPTH));
    assign rom_addr_out = fetch_pc;
    assign accept       = rom_req_out && rom_ready_in;

    // A response landing during a jump belongs to the old stream and is dropped.
    assign push = inflight && !drop && !jump_flag_in;
    assign pop  = inst_valid_out && inst_ready_in;

    assign inst_valid_out = (count != '0) && !jump_flag_in;
    assign inst_out       = inst_valid_out ? q_inst[rd_ptr] : INST_NOP;
    assign inst_addr_out  = inst_valid_out ? q_addr[rd_ptr] : '0;
    assign count_out      = count;

    // Fetch PC, in-flight tracking and queue bookkeeping, with jump taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc      <= RST_ADDR;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            drop          <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else if (jump_flag_in) begin
            fetch_pc <= jump_target;
            inflight <= 1'b0;
            drop     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                inflight      <= 1'b1;
                inflight_addr <= fetch_pc;
                fetch_pc      <= fetch_pc + ADDR_W'(4);
            end else begin
                inflight <= 1'b0;
            end
            if (inflight && drop) begin
                drop <= 1'b0;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_addr[wr_ptr] <= inflight_addr;
            q_inst[wr_ptr] <= rom_data_in;
        end
    end

endmodule

// File: tb/tb_core_ifetch_queue.sv
// Testbench for core_ifetch_queue: two instances (DEPTH=4 from address 0, and
// DEPTH=3 from 0xFFFFFFF8) share control inputs; each is compared every cycle
// against a queue-based reference model, plus directed checks per scenario.
module tb_core_ifetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        hold_flag;
    logic        rom_ready;
    logic        inst_ready;
    logic [31:0] rom_data0, rom_data1;

    logic        req0, req1, valid0, valid1;
    logic [31:0] raddr0, raddr1, inst0, inst1, iaddr0, iaddr1;
    logic [2:0]  cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    int          depth [2];
    logic [31:0] rst_addr [2];
    logic [31:0] m_pc [2];
    logic        m_inflight [2];
    logic [31:0] m_infaddr [2];
    logic        m_drop [2];
    logic [63:0] mq [2][$];

    logic [31:0] stall_addr;

    always #5 clk = ~clk;

    core_ifetch_queue #(.DEPTH(4), .RST_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .jump_flag_in(jump_flag), .jump_addr_in(jump_addr),
        .hold_flag_in(hold_flag), .rom_req_out(req0), .rom_addr_out(raddr0),
        .rom_ready_in(rom_ready), .rom_data_in(rom_data0), .inst_valid_out(valid0),
        .inst_out(inst0), .inst_addr_out(iaddr0), .inst_ready_in(inst_ready),
        .count_out(cnt0)
    );

    core_ifetch_queue #(.DEPTH(3), .RST_ADDR(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .jump_flag_in(jump_flag), .jump_addr_in(jump_addr),
        .hold_flag_in(hold_flag), .rom_req_out(req1), .rom_addr_out(raddr1),
        .rom_ready_in(rom_ready), .rom_data_in(rom_data1), .inst_valid_out(valid1),
        .inst_out(inst1), .inst_addr_out(iaddr1), .inst_ready_in(inst_ready),
        .count_out(cnt1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare one instance against what the model says it should show now.
    task automatic checkDut(input int k);
        int          n;
        logic        e_req, e_valid;
        logic [31:0] e_inst, e_iaddr;
        n       = mq[k].size();
        e_req   = !rst && !jump_flag && !hold_flag && ((n + int'(m_inflight[k])) < depth[k]);
        e_valid = (n != 0) && !jump_flag;
        e_inst  = e_valid ? mq[k][0][31:0] : NOP;
        e_iaddr = e_valid ? mq[k][0][63:32] : 32'h0;
        checkOutput($sformatf("d%0d_req", k),   32'(k == 0 ? req0 : req1), 32'(e_req));
        checkOutput($sformatf("d%0d_raddr", k), k == 0 ? raddr0 : raddr1, m_pc[k]);
        checkOutput($sformatf("d%0d_valid", k), 32'(k == 0 ? valid0 : valid1), 32'(e_valid));
        checkOutput($sformatf("d%0d_inst", k),  k == 0 ? inst0 : inst1, e_inst);
        checkOutput($sformatf("d%0d_iaddr", k), k == 0 ? iaddr0 : iaddr1, e_iaddr);
        checkOutput($sformatf("d%0d_count", k), k == 0 ? 32'(cnt0) : 32'(cnt1), 32'(n));
    endtask

    // Advance the model across the coming clock edge.
    task automatic modelStep(input int k);
        int          n;
        logic        e_req;
        logic [31:0] data;
        n     = mq[k].size();
        e_req = !rst && !jump_flag && !hold_flag && ((n + int'(m_inflight[k])) < depth[k]);
        data  = (k == 0) ? rom_data0 : rom_data1;
        if (rst) begin
            m_pc[k]       = rst_addr[k];
            m_inflight[k] = 1'b0;
            m_drop[k]     = 1'b0;
            mq[k].delete();
        end else if (jump_flag) begin
            m_pc[k]       = {jump_addr[31:2], 2'b00};
            m_inflight[k] = 1'b0;
            m_drop[k]     = 1'b0;
            mq[k].delete();
        end else begin
            if (n != 0 && inst_ready) void'(mq[k].pop_front());
            if (m_inflight[k]) begin
                if (m_drop[k]) m_drop[k] = 1'b0;
                else mq[k].push_back({m_infaddr[k], data});
            end
            if (e_req && rom_ready) begin
                m_inflight[k] = 1'b1;
                m_infaddr[k]  = m_pc[k];
                m_pc[k]       = m_pc[k] + 32'd4;
            end else begin
                m_inflight[k] = 1'b0;
            end
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then step the model.
    task automatic applyStimulus(input logic r, input logic j, input logic [31:0] ja,
                                 input logic h, input logic rr, input logic ir);
        @(negedge clk);
        rst        = r;
        jump_flag  = j;
        jump_addr  = ja;
        hold_flag  = h;
        rom_ready  = rr;
        inst_ready = ir;
        rom_data0  = m_inflight[0] ? (m_infaddr[0] >> 2) : $urandom();
        rom_data1  = m_inflight[1] ? (m_infaddr[1] >> 2) : $urandom();
        #1;
        checkDut(0);
        checkDut(1);
        modelStep(0);
        modelStep(1);
    endtask

    initial begin
        depth[0] = 4;  rst_addr[0] = 32'h0000_0000;
        depth[1] = 3;  rst_addr[1] = 32'hFFFF_FFF8;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = rst_addr[k]; m_inflight[k] = 1'b0; m_infaddr[k] = '0; m_drop[k] = 1'b0;
        end
        rst = 1'b1; jump_flag = 1'b0; jump_addr = '0; hold_flag = 1'b0;
        rom_ready = 1'b1; inst_ready = 1'b1; rom_data0 = '0; rom_data1 = '0;
        $display("[TB] start");

        // Reset state
        applyStimulus(1, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 1, 1);
        checkOutput("rst_req", 32'(req0), 32'h0);
        checkOutput("rst_inst", inst0, NOP);
        checkOutput("rst_count", 32'(cnt0), 32'h0);

        // Reset and stream
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("stream_addr0", raddr0, 32'h0);
        checkOutput("stream_req0", 32'(req0), 32'h1);
        checkOutput("wrap_addr0", raddr1, 32'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("stream_addr1", raddr0, 32'h4);
        checkOutput("wrap_addr1", raddr1, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("stream_first_valid", 32'(valid0), 32'h1);
        checkOutput("stream_first_iaddr", iaddr0, 32'h0);
        checkOutput("wrap_addr2", raddr1, 32'h0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        // Backpressure until full
        applyStimulus(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("full_count", 32'(cnt0), 32'h4);
        checkOutput("full_req", 32'(req0), 32'h0);
        checkOutput("full_pc", raddr0, 32'h10);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("drain_iaddr0", iaddr0, 32'h0);
        checkOutput("drain_req_blocked", 32'(req0), 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("drain_iaddr4", iaddr0, 32'h4);
        checkOutput("resume_addr", raddr0, 32'h10);
        checkOutput("resume_req", 32'(req0), 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("drain_iaddr8", iaddr0, 32'h8);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("drain_iaddr12", iaddr0, 32'hC);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("drain_iaddr16", iaddr0, 32'h10);

        // Jump with a response in flight
        applyStimulus(0, 1, 32'h103, 0, 1, 1);
        checkOutput("jump_req", 32'(req0), 32'h0);
        checkOutput("jump_valid", 32'(valid0), 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("jump_count", 32'(cnt0), 32'h0);
        checkOutput("jump_target", raddr0, 32'h100);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("jump_t2_valid", 32'(valid0), 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("jump_t3_valid", 32'(valid0), 32'h1);
        checkOutput("jump_t3_iaddr", iaddr0, 32'h100);
        checkOutput("jump_t3_inst", inst0, 32'h40);

        // ROM stall
        stall_addr = m_pc[0];
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkOutput("stall_req", 32'(req0), 32'h1);
            checkOutput("stall_addr", raddr0, stall_addr);
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        // Hold with two queued and one in flight
        applyStimulus(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("hold_req", 32'(req0), 32'h0);
        checkOutput("hold_count2", 32'(cnt0), 32'h2);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("hold_count3", 32'(cnt0), 32'h3);
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("hold_pop0", iaddr0, 32'h0);
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("hold_pop4", iaddr0, 32'h4);
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("hold_pop8", iaddr0, 32'h8);
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("hold_empty_valid", 32'(valid0), 32'h0);
        checkOutput("hold_empty_inst", inst0, NOP);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom(),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
